// File: rtl/conv_kernel_store.sv
// conv_kernel_store: weight/bias register store for one conv layer.
// Build option: CONV_KERNEL_STORE_CHECKSUM_EN adds a running checksum output.
module conv_kernel_store #(
  parameter int DATA_WIDTH    = 16,
  parameter int KER_ADR_WIDTH = 8,
  parameter int KER_WIDTH     = 5,
  parameter int KER_HEIGHT    = 5,
  parameter int IN_CHANNEL    = 1,
  parameter int OUT_CHANNEL   = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_start,
  input  logic                     load_valid,
  input  logic [DATA_WIDTH-1:0]    load_data,
  output logic                     load_ready,
  output logic                     load_done,
  output logic                     loaded,
  input  logic                     in_ker_wb,
  input  logic [KER_ADR_WIDTH-1:0] in_ker_x,
  input  logic [KER_ADR_WIDTH-1:0] in_ker_y,
  input  logic [KER_ADR_WIDTH-1:0] in_ker_chIn,
  input  logic [KER_ADR_WIDTH-1:0] in_ker_chOut,
  output logic [DATA_WIDTH-1:0]    out_ker_data
`ifdef CONV_KERNEL_STORE_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]    checksum
`endif
);

  localparam int NW = KER_WIDTH * KER_HEIGHT * IN_CHANNEL * OUT_CHANNEL;
  localparam int NB = OUT_CHANNEL;
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;
  localparam int BW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    LOAD_W,
    LOAD_B,
    READY
  } state_e;

  state_e          state_q, state_d;
  logic [WW-1:0]   wcnt_q, wcnt_d;
  logic [BW-1:0]   bcnt_q, bcnt_d;
  logic            ready_q, ready_d;
  logic            done_q, done_d;
  logic            loaded_q, loaded_d;
  logic            xfer;
  logic            we_w, we_b;

  logic [DATA_WIDTH-1:0] wmem_q [NW];
  logic [DATA_WIDTH-1:0] bmem_q [NB];

`ifdef CONV_KERNEL_STORE_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] csum_q, csum_d;
`endif

  assign xfer = load_valid & ready_q;
  assign we_w = xfer & (state_q == LOAD_W) & ~rst;
  assign we_b = xfer & (state_q == LOAD_B) & ~rst;

  // Next-state logic for the load sequencer and its registered outputs.
  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    bcnt_d   = bcnt_q;
    ready_d  = ready_q;
    loaded_d = loaded_q;
    done_d   = 1'b0;
`ifdef CONV_KERNEL_STORE_CHECKSUM_EN
    csum_d   = csum_q;
    if (xfer) csum_d = csum_q + load_data;
`endif
    unique case (state_q)
      IDLE, READY: begin
        if (load_start) begin
          state_d  = LOAD_W;
          wcnt_d   = '0;
          bcnt_d   = '0;
          loaded_d = 1'b0;
          ready_d  = 1'b1;
`ifdef CONV_KERNEL_STORE_CHECKSUM_EN
          csum_d   = '0;
`endif
        end
      end
      LOAD_W: begin
        if (xfer) begin
          wcnt_d = wcnt_q + WW'(1);
          if (wcnt_q == WW'(NW - 1)) state_d = LOAD_B;
        end
      end
      LOAD_B: begin
        if (xfer) begin
          bcnt_d = bcnt_q + BW'(1);
          if (bcnt_q == BW'(NB - 1)) begin
            state_d  = READY;
            ready_d  = 1'b0;
            loaded_d = 1'b1;
            done_d   = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer state, counters and handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      wcnt_q   <= '0;
      bcnt_q   <= '0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
      loaded_q <= 1'b0;
`ifdef CONV_KERNEL_STORE_CHECKSUM_EN
      csum_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wcnt_q   <= wcnt_d;
      bcnt_q   <= bcnt_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      loaded_q <= loaded_d;
`ifdef CONV_KERNEL_STORE_CHECKSUM_EN
      csum_q   <= csum_d;
`endif
    end
  end

  // Storage array; contents survive reset and are hidden by loaded.
  always_ff @(posedge clk) begin
    if (we_w) wmem_q[wcnt_q] <= load_data;
    if (we_b) bmem_q[bcnt_q] <= load_data;
  end

  logic [31:0]   x32, y32, ci32, co32;
  logic          hit;
  logic [WW-1:0] widx;

  // Zero-latency lookup with range and loaded masking.
  always_comb begin
    x32  = 32'(in_ker_x);
    y32  = 32'(in_ker_y);
    ci32 = 32'(in_ker_chIn);
    co32 = 32'(in_ker_chOut);
    hit  = (x32 < 32'(KER_WIDTH)) && (y32 < 32'(KER_HEIGHT)) &&
           (ci32 < 32'(IN_CHANNEL)) && (co32 < 32'(OUT_CHANNEL));
    widx = WW'(((co32 * 32'(IN_CHANNEL) + ci32) * 32'(KER_HEIGHT) + y32)
               * 32'(KER_WIDTH) + x32);
    out_ker_data = '0;
    if (loaded_q && hit) begin
      if (in_ker_wb) out_ker_data = wmem_q[widx];
      else           out_ker_data = bmem_q[co32[BW-1:0]];
    end
  end

  assign load_ready = ready_q;
  assign load_done  = done_q;
  assign loaded     = loaded_q;
`ifdef CONV_KERNEL_STORE_CHECKSUM_EN
  assign checksum   = csum_q;
`endif

endmodule
